// File: rtl/pipe_seq_ctrl.sv
// pipe_seq_ctrl: host command sequencer that loads, reads and runs a pipeline.
// Define PC_BREAK_EN to stop RUN when PC hits the command address (rsp_err=1).
module pipe_seq_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [8:0]       cmd_addr,
   input  logic [63:0]      cmd_data,
   input  logic [CNT_W-1:0] cmd_count,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [63:0]      rsp_data,
   output logic             rsp_err,
   input  logic             run_abort,
   output logic             pipe_en,
   output logic             imem_we,
   output logic             imem_re,
   output logic [8:0]       imem_addr,
   output logic [31:0]      imem_data,
   output logic             dmem_we,
   output logic             dmem_re,
   output logic [7:0]       dmem_addr,
   output logic [63:0]      dmem_data,
   output logic             reg_re,
   output logic [3:0]       reg_addr,
   input  logic [63:0]      dmem_out,
   input  logic [63:0]      reg_out,
   input  logic [8:0]       PC
);

   localparam logic [2:0] OP_NOP = 3'd0;
   localparam logic [2:0] OP_IMW = 3'd1;
   localparam logic [2:0] OP_DMW = 3'd2;
   localparam logic [2:0] OP_RRD = 3'd3;
   localparam logic [2:0] OP_DRD = 3'd4;
   localparam logic [2:0] OP_RUN = 3'd5;

   typedef enum logic [2:0] {
      IDLE, WRITE, RD_ADDR, RD_CAP, RUN, RESP
   } state_t;

   state_t           state, state_nx;
   logic [2:0]       op_q;
   logic [8:0]       addr_q;
   logic [63:0]      data_q;
   logic [CNT_W-1:0] count_q, cnt_q, cnt_nx, cnt_inc;
   logic [63:0]      rsp_q, rsp_nx;
   logic             err_q, err_nx;
   logic             accept, brk, stop;

   assign cmd_ready = reset && (state == IDLE);
   assign accept    = cmd_valid && cmd_ready;
   assign imem_re   = 1'b0;
   assign cnt_inc   = cnt_q + CNT_W'(1);

`ifdef PC_BREAK_EN
   assign brk = (PC == addr_q);
`else
   assign brk = 1'b0;
`endif

   assign stop = (cnt_inc == count_q) || run_abort || brk;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= IDLE;
         op_q    <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         count_q <= '0;
         cnt_q   <= '0;
         rsp_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state <= state_nx;
         cnt_q <= cnt_nx;
         rsp_q <= rsp_nx;
         err_q <= err_nx;
         if (accept) begin
            op_q    <= cmd_op;
            addr_q  <= cmd_addr;
            data_q  <= cmd_data;
            count_q <= cmd_count;
         end
      end
   end

   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt_q;
      rsp_nx    = rsp_q;
      err_nx    = err_q;
      pipe_en   = 1'b0;
      imem_we   = 1'b0;
      imem_addr = '0;
      imem_data = '0;
      dmem_we   = 1'b0;
      dmem_re   = 1'b0;
      dmem_addr = '0;
      dmem_data = '0;
      reg_re    = 1'b0;
      reg_addr  = '0;
      rsp_valid = 1'b0;
      rsp_data  = '0;
      rsp_err   = 1'b0;
      unique case (state)
         IDLE: begin
            if (accept) begin
               cnt_nx = '0;
               rsp_nx = '0;
               err_nx = 1'b0;
               unique case (1'b1)
                  (cmd_op == OP_NOP): state_nx = RESP;
                  (cmd_op == OP_IMW),
                  (cmd_op == OP_DMW): state_nx = WRITE;
                  (cmd_op == OP_RRD),
                  (cmd_op == OP_DRD): state_nx = RD_ADDR;
                  (cmd_op == OP_RUN): begin
                     if (cmd_count == '0) begin
                        rsp_nx   = {55'd0, PC};
                        state_nx = RESP;
                     end else begin
                        state_nx = RUN;
                     end
                  end
                  default: begin
                     err_nx   = 1'b1;
                     state_nx = RESP;
                  end
               endcase
            end
         end
         WRITE: begin
            if (op_q == OP_IMW) begin
               imem_we   = 1'b1;
               imem_addr = addr_q;
               imem_data = data_q[31:0];
            end else begin
               dmem_we   = 1'b1;
               dmem_addr = addr_q[7:0];
               dmem_data = data_q;
            end
            state_nx = RESP;
         end
         RD_ADDR, RD_CAP: begin
            if (op_q == OP_RRD) begin
               reg_re   = 1'b1;
               reg_addr = addr_q[3:0];
            end else begin
               dmem_re   = 1'b1;
               dmem_addr = addr_q[7:0];
            end
            if (state == RD_CAP) begin
               rsp_nx   = (op_q == OP_RRD) ? reg_out : dmem_out;
               state_nx = RESP;
            end else begin
               state_nx = RD_CAP;
            end
         end
         RUN: begin
            pipe_en = 1'b1;
            cnt_nx  = cnt_inc;
            // cnt_inc already includes the cycle that is ending now
            if (stop) begin
               rsp_nx   = {32'(cnt_inc), 23'd0, PC};
               err_nx   = brk;
               state_nx = RESP;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            rsp_data  = rsp_q;
            rsp_err   = err_q;
            if (rsp_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// tb_pipe_seq_ctrl: directed bench with a transaction-level sequencer model.
// Define PC_BREAK_EN to also exercise the PC breakpoint stop.
module tb_pipe_seq_ctrl;

   localparam int CW = 16;

   typedef enum int {K_NONE, K_IW, K_DW, K_RR, K_DR, K_RUN} kind_e;

   typedef struct {
      kind_e       kind;
      int          lat;
      logic [8:0]  addr;
      logic [63:0] wdata;
      logic [63:0] data;
      logic        err;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          cmd_valid, cmd_ready;
   logic [2:0]    cmd_op;
   logic [8:0]    cmd_addr;
   logic [63:0]   cmd_data;
   logic [CW-1:0] cmd_count;
   logic          rsp_valid, rsp_ready, rsp_err;
   logic [63:0]   rsp_data;
   logic          run_abort;
   logic          pipe_en, imem_we, imem_re;
   logic [8:0]    imem_addr;
   logic [31:0]   imem_data;
   logic          dmem_we, dmem_re;
   logic [7:0]    dmem_addr;
   logic [63:0]   dmem_data;
   logic          reg_re;
   logic [3:0]    reg_addr;
   logic [63:0]   dmem_out = '0;
   logic [63:0]   reg_out = '0;
   logic [8:0]    pc = '0;
   logic          pc_load;
   logic [8:0]    pc_init;

   int checks = 0;
   int failures = 0;

   exp_t        exp_q[$];
   logic [63:0] ref_dmem [256];
   logic [63:0] dmem_arr [256];
   logic [255:0] dmem_vld = '0;

   logic [63:0] last_rsp_data;
   logic        last_rsp_err;
   logic [8:0]  last_iw_addr;
   logic [31:0] last_iw_data;
   int          pipe_cnt, iw_cnt, first_lat;

   pipe_seq_ctrl #(.CNT_W(CW)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_addr(cmd_addr),
      .cmd_data(cmd_data), .cmd_count(cmd_count),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_err(rsp_err),
      .run_abort(run_abort), .pipe_en(pipe_en),
      .imem_we(imem_we), .imem_re(imem_re),
      .imem_addr(imem_addr), .imem_data(imem_data),
      .dmem_we(dmem_we), .dmem_re(dmem_re),
      .dmem_addr(dmem_addr), .dmem_data(dmem_data),
      .reg_re(reg_re), .reg_addr(reg_addr),
      .dmem_out(dmem_out), .reg_out(reg_out), .PC(pc)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] reg_val(input logic [3:0] i);
      return 64'hC0DE_0000_0000_0000 | (64'(i) * 64'd3);
   endfunction

   // pipeline stand-in: sync-read memories and a PC that steps on pipe_en
   always @(posedge clk) begin
      if (dmem_we) begin
         dmem_arr[dmem_addr] <= dmem_data;
         dmem_vld[dmem_addr] <= 1'b1;
      end
      if (dmem_re)
         dmem_out <= dmem_vld[dmem_addr] ? dmem_arr[dmem_addr] : 64'd0;
      if (reg_re) reg_out <= reg_val(reg_addr);
      if (pc_load) pc <= pc_init;
      else if (pipe_en) pc <= pc + 9'd1;
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
      end
   endtask

   task automatic make_exp(input logic [2:0] op, input logic [8:0] addr,
                           input logic [63:0] data, input logic [CW-1:0] count,
                           input int abort_k, output exp_t e);
      int n, kb;
      logic [8:0] p;
      e.kind = K_NONE;
      e.lat = 0;
      e.addr = addr;
      e.wdata = data;
      e.data = '0;
      e.err = 1'b0;
      kb = 0;
      case (op)
         3'd0: ;
         3'd1: begin e.kind = K_IW; e.lat = 1; end
         3'd2: begin
            e.kind = K_DW;
            e.lat = 1;
            ref_dmem[addr[7:0]] = data;
         end
         3'd3: begin e.kind = K_RR; e.lat = 2; e.data = reg_val(addr[3:0]); end
         3'd4: begin e.kind = K_DR; e.lat = 2; e.data = ref_dmem[addr[7:0]]; end
         3'd5: begin
            e.kind = K_RUN;
            n = int'(count);
            if (abort_k > 0 && abort_k < n) n = abort_k;
`ifdef PC_BREAK_EN
            for (int k = 1; k <= n; k++) begin
               p = pc + 9'(k - 1);
               if (p == addr) begin
                  kb = k;
                  break;
               end
            end
            if (kb > 0) n = kb;
`endif
            e.err = (kb > 0);
            e.lat = n;
            if (n == 0) begin
               e.data = {55'd0, pc};
            end else begin
               p = pc + 9'(n - 1);
               e.data = {32'(n), 23'd0, p};
            end
         end
         default: e.err = 1'b1;
      endcase
   endtask

   task automatic wait_idle();
      for (int g = 0; g < 50 && !cmd_ready; g++) @(negedge clk);
      chk("idle_wait", cmd_ready, 1);
   endtask

   task automatic issue(input logic [2:0] op, input logic [8:0] addr,
                        input logic [63:0] data, input logic [CW-1:0] count,
                        input int abort_k, input int rdly);
      exp_t e;
      int held;
      bit done;
      wait_idle();
      make_exp(op, addr, data, count, abort_k, e);
      exp_q.push_back(e);
      cmd_op = op;
      cmd_addr = addr;
      cmd_data = data;
      cmd_count = count;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_data = '0;
      held = 0;
      done = 0;
      for (int j = 1; j <= 400 && !done; j++) begin
         run_abort = (j == abort_k);
         if (rsp_valid) begin
            if (held >= rdly) begin
               rsp_ready = 1'b1;
               done = 1;
            end else begin
               held++;
            end
         end
         @(negedge clk);
      end
      rsp_ready = 1'b0;
      run_abort = 1'b0;
      chk("rsp_handshake", done, 1);
   endtask

   // cycle checker: expected outputs follow from the current transaction
   initial begin
      bit acc, hs, rst, busy, armed;
      bit e_iw, e_dw, e_rr, e_dr, e_v, e_pe;
      int since;
      exp_t cur;
      busy = 0;
      armed = 0;
      since = 0;
      cur.kind = K_NONE;
      cur.lat = 0;
      cur.addr = '0;
      cur.wdata = '0;
      cur.data = '0;
      cur.err = 1'b0;
      forever begin
         @(posedge clk);
         rst = (reset !== 1'b1);
         acc = !rst && cmd_valid && cmd_ready;
         hs = !rst && rsp_valid && rsp_ready;
         if (hs) begin
            last_rsp_data = rsp_data;
            last_rsp_err = rsp_err;
         end
         #1;
         if (rst) begin
            busy = 0;
            armed = 1;
         end else if (acc) begin
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL accept: unexpected command acceptance at %0t", $time);
            end else begin
               cur = exp_q.pop_front();
            end
            busy = 1;
            since = 0;
            pipe_cnt = 0;
            iw_cnt = 0;
            first_lat = -1;
         end else if (hs) begin
            busy = 0;
         end else if (busy) begin
            since++;
         end
         if (armed) begin
            e_v  = busy && since >= cur.lat;
            e_pe = busy && cur.kind == K_RUN && since < cur.lat;
            e_iw = busy && cur.kind == K_IW && since == 0;
            e_dw = busy && cur.kind == K_DW && since == 0;
            e_rr = busy && cur.kind == K_RR && since < 2;
            e_dr = busy && cur.kind == K_DR && since < 2;
            chk("cmd_ready", cmd_ready, !busy && reset);
            chk("rsp_valid", rsp_valid, e_v);
            chk("rsp_data", rsp_data, e_v ? cur.data : 64'd0);
            chk("rsp_err", rsp_err, e_v ? cur.err : 1'b0);
            chk("pipe_en", pipe_en, e_pe);
            chk("imem_re", imem_re, 0);
            chk("imem_we", imem_we, e_iw);
            chk("imem_addr", imem_addr, e_iw ? cur.addr : 9'd0);
            chk("imem_data", imem_data, e_iw ? cur.wdata[31:0] : 32'd0);
            chk("dmem_we", dmem_we, e_dw);
            chk("dmem_re", dmem_re, e_dr);
            chk("dmem_addr", dmem_addr,
                (e_dw || e_dr) ? cur.addr[7:0] : 8'd0);
            chk("dmem_data", dmem_data, e_dw ? cur.wdata : 64'd0);
            chk("reg_re", reg_re, e_rr);
            chk("reg_addr", reg_addr, e_rr ? cur.addr[3:0] : 4'd0);
            if (pipe_en) pipe_cnt++;
            if (imem_we) begin
               iw_cnt++;
               last_iw_addr = imem_addr;
               last_iw_data = imem_data;
            end
            if (rsp_valid && first_lat < 0) first_lat = since;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen;
      exp_t e;
      cmd_valid = 0;
      cmd_op = '0;
      cmd_addr = '0;
      cmd_data = '0;
      cmd_count = '0;
      rsp_ready = 0;
      run_abort = 0;
      reset = 0;
      pc_load = 1;
      pc_init = '0;
      for (int i = 0; i < 256; i++) ref_dmem[i] = '0;
      repeat (3) @(negedge clk);
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_pipe_en", pipe_en, 0);
      reset = 1;
      pc_load = 0;
      @(negedge clk);
      chk("cmd_ready_after_rst", cmd_ready, 1);

      issue(3'd1, 9'h005, 64'hE0812003, '0, 0, 0);
      chk("iw_pulses", iw_cnt, 1);
      chk("iw_addr", last_iw_addr, 9'h005);
      chk("iw_data", last_iw_data, 32'hE0812003);
      chk("iw_err", last_rsp_err, 0);

      issue(3'd2, 9'h010, 64'h55, '0, 0, 0);
      issue(3'd4, 9'h010, '0, '0, 0, 0);
      chk("dr_data", last_rsp_data, 64'h55);
      chk("dr_latency", first_lat, 2);

      issue(3'd2, 9'h000, 64'hDEAD_BEEF_0123_4567, '0, 0, 0);
      issue(3'd2, 9'h0FF, 64'hFFFF_FFFF_FFFF_FFFF, '0, 0, 0);
      issue(3'd2, 9'h1AB, 64'h0123_4567_89AB_CDEF, '0, 0, 0);
      issue(3'd4, 9'h0AB, '0, '0, 0, 0);
      chk("dr_addr_trunc", last_rsp_data, 64'h0123_4567_89AB_CDEF);
      issue(3'd4, 9'h0FF, '0, '0, 0, 0);
      issue(3'd4, 9'h000, '0, '0, 0, 2);
      issue(3'd4, 9'h033, '0, '0, 0, 0);
      chk("dr_unwritten", last_rsp_data, 64'd0);

      issue(3'd5, 9'h1FF, '0, 16'd7, 0, 0);
      chk("run7_pipe", pipe_cnt, 7);
      chk("run7_cycles", last_rsp_data[63:32], 7);
      chk("run7_pc", last_rsp_data[8:0], 6);
      chk("run7_err", last_rsp_err, 0);

      issue(3'd5, 9'h1FF, '0, 16'd0, 0, 0);
      chk("run0_pipe", pipe_cnt, 0);
      chk("run0_data", last_rsp_data, 64'd7);

      issue(3'd5, 9'h1FF, '0, 16'd100, 4, 0);
      chk("abort_pipe", pipe_cnt, 4);
      chk("abort_cycles", last_rsp_data[63:32], 4);
      chk("abort_pc", last_rsp_data[8:0], 10);

      issue(3'd5, 9'h1FF, '0, 16'd1, 1, 0);
      chk("run1_abort_pipe", pipe_cnt, 1);

      issue(3'd0, 9'h0AA, 64'h1234, '0, 0, 5);
      chk("nop_data", last_rsp_data, 64'd0);
      chk("nop_err", last_rsp_err, 0);
      chk("nop_latency", first_lat, 0);

      issue(3'd7, 9'h001, 64'h99, '0, 0, 0);
      chk("op7_err", last_rsp_err, 1);
      chk("op7_data", last_rsp_data, 64'd0);
      issue(3'd6, 9'h001, 64'h99, '0, 0, 1);
      chk("op6_err", last_rsp_err, 1);

      issue(3'd3, 9'h005, '0, '0, 1, 0);
      chk("rr_data", last_rsp_data, 64'hC0DE_0000_0000_000F);
      issue(3'd3, 9'h1FF, '0, '0, 0, 0);

      // reset while RUN is active: pipe_en drops, no response follows
      wait_idle();
      make_exp(3'd5, 9'h1FF, '0, 16'd30, 0, e);
      exp_q.push_back(e);
      cmd_op = 3'd5;
      cmd_addr = 9'h1FF;
      cmd_count = 16'd30;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("mid_run_pipe_en", pipe_en, 1);
      reset = 0;
      @(negedge clk);
      chk("rst_run_pipe_en", pipe_en, 0);
      chk("rst_run_rsp", rsp_valid, 0);
      reset = 1;
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (rsp_valid) seen++;
      end
      chk("rst_discard_rsp", seen, 0);

      issue(3'd5, 9'h1FF, '0, 16'd3, 0, 0);
      chk("run3_pipe", pipe_cnt, 3);
      chk("run3_cycles", last_rsp_data[63:32], 3);

`ifdef PC_BREAK_EN
      pc_load = 1;
      pc_init = '0;
      @(negedge clk);
      pc_load = 0;
      issue(3'd5, 9'd3, '0, 16'd50, 0, 0);
      chk("brk_pipe", pipe_cnt, 4);
      chk("brk_err", last_rsp_err, 1);
      chk("brk_pc", last_rsp_data[8:0], 3);
      chk("brk_cycles", last_rsp_data[63:32], 4);
`endif

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
